// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC sharing arbiter: FSM state encoding,
// phase range limit and the response record.
// Optional engine watchdog is enabled with CORDIC_ARB_TIMEOUT_EN (see top).
package cordic_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} arb_state_t;

  localparam int PKG_EXPAND_BIT = 16;
  // 360 degrees in fixed point; phases at or above this are rejected
  localparam longint PHASE_MAX = longint'(360) << PKG_EXPAND_BIT;

  function automatic longint phase_max(input int expand_bit);
    return longint'(360) << expand_bit;
  endfunction

  // Response record sized for the widest supported configuration
  // (NUM_REQ <= 8, DATA_WIDTH <= 64); the top narrows it on output.
  localparam int RSP_IDW = 3;
  localparam int RSP_DW  = 64;

  typedef struct packed {
    logic [RSP_IDW-1:0] id;
    logic [RSP_DW-1:0]  sin;
    logic [RSP_DW-1:0]  cos;
    logic               err;
  } rsp_t;

endpackage

// File: rtl/cordic_share_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [ID_W-1:0] idx;
  logic            found;

  // Walk the ring starting at ptr, stop at the first requester
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en && !found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/cordic_share_arb.sv
// Shares one iterative sin/cos CORDIC engine between NUM_REQ requesters:
// round-robin grant, phase range check, one-cycle engine start, and a single
// valid/ready response port tagged with the requester id.
// Define CORDIC_ARB_TIMEOUT_EN to add an engine watchdog of TIMEOUT cycles.
module cordic_share_arb
  import cordic_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ),
  parameter int DATA_WIDTH = 32,
  parameter int EXPAND_BIT = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_phase,
  output logic                          eng_start,
  output logic [DATA_WIDTH-1:0]         eng_phase,
  input  logic                          eng_done,
  input  logic [DATA_WIDTH-1:0]         eng_sin,
  input  logic [DATA_WIDTH-1:0]         eng_cos,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_sin,
  output logic [DATA_WIDTH-1:0]         rsp_cos,
  output logic                          rsp_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH > RSP_DW || TIMEOUT < 1) begin : g_bad_cfg
    $error("cordic_share_arb: unsupported parameter set");
  end

  localparam logic [DATA_WIDTH:0] PMAX = (DATA_WIDTH+1)'(phase_max(EXPAND_BIT));

  arb_state_t             state_q, state_d;
  logic                   run_q;
  logic [ID_W-1:0]        ptr_q, ptr_nxt, gnt_idx;
  logic [NUM_REQ-1:0]     gnt;
  logic                   hs, in_range, to_hit;
  logic [DATA_WIDTH-1:0]  gnt_phase;
  rsp_t                   rsp_q;

  // run_q keeps req_ready low while reset is asserted and for the first edge after
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (state_q == IDLE && run_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);
  assign in_range  = {1'b0, gnt_phase} < PMAX;
  assign ptr_nxt   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Phase mux driven by the one-hot grant
  always_comb begin
    gnt_phase = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_phase = req_phase[i*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

  // Watchdog: cleared on issue, counts BUSY cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                to_cnt_q <= '0;
    else if (state_q == ISSUE) to_cnt_q <= '0;
    else if (state_q == BUSY)  to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state: eng_done only matters while BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = in_range ? ISSUE : RESP;
      ISSUE:   state_d = BUSY;
      BUSY:    if (eng_done || to_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer, engine phase and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      eng_phase <= '0;
      rsp_q     <= '0;
    end else if (hs) begin
      ptr_q     <= ptr_nxt;
      rsp_q.id  <= RSP_IDW'(gnt_idx);
      rsp_q.sin <= '0;
      rsp_q.cos <= '0;
      rsp_q.err <= !in_range;
      if (in_range) eng_phase <= gnt_phase;
    end else if (state_q == BUSY) begin
      if (eng_done) begin
        rsp_q.sin <= RSP_DW'(eng_sin);
        rsp_q.cos <= RSP_DW'(eng_cos);
        rsp_q.err <= 1'b0;
      end else if (to_hit) begin
        rsp_q.sin <= '0;
        rsp_q.cos <= '0;
        rsp_q.err <= 1'b1;
      end
    end
  end

  assign eng_start = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = ID_W'(rsp_q.id);
  assign rsp_sin   = DATA_WIDTH'(rsp_q.sin);
  assign rsp_cos   = DATA_WIDTH'(rsp_q.cos);
  assign rsp_err   = rsp_q.err;

endmodule
